// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks a pc through a combinational ROM and
// hands words to a valid/ready consumer, with redirect, halt-word and bad-pc fault handling.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   FETCH   | fetching one word per free output slot
//   HALTED  | halt word delivered; no fetches until redirect or reset
//   FAULT   | pc misaligned or past end of ROM; no fetches, pc held
module instr_fetch_ctrl #(
   parameter int unsigned MEM_SIZE  = 1024,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter logic [31:0] HALT_WORD = 32'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [1:0]  state,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } fetch_state_e;

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

   fetch_state_e st_q, st_d;
   logic [31:0]  pc_q, pc_d;
   logic         vld_q, vld_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  opc_q, opc_d;
   logic [15:0]  cnt_q, cnt_d;

   logic         slot_free;
   logic         accept;
   logic         pc_bad;
   logic [32:0]  pc_last_byte;

   assign slot_free    = !vld_q || out_ready;
   assign accept       = vld_q && out_ready;
   // Widened so a pc near the top of the address space cannot wrap into range.
   assign pc_last_byte = {1'b0, pc_q} + 33'd3;
   assign pc_bad       = (pc_q[1:0] != 2'b00) || (pc_last_byte >= MEM_LIMIT);

   always_comb begin
      st_d    = st_q;
      pc_d    = pc_q;
      vld_d   = vld_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      cnt_d   = cnt_q;
      if (redirect_valid) begin
         pc_d  = redirect_pc;
         vld_d = 1'b0;
         st_d  = ST_FETCH;
      end else begin
         if (accept && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
         end
         case (st_q)
            ST_FETCH: begin
               if (slot_free) begin
                  if (pc_bad) begin
                     vld_d = 1'b0;
                     st_d  = ST_FAULT;
                  end else begin
                     instr_d = imem_instr;
                     opc_d   = pc_q;
                     vld_d   = 1'b1;
                     pc_d    = pc_q + 32'd4;
                     if (imem_instr == HALT_WORD) begin
                        st_d = ST_HALTED;
                     end
                  end
               end
            end
            ST_HALTED, ST_FAULT: begin
               if (accept) begin
                  vld_d = 1'b0;
               end
            end
            default: begin
               vld_d = 1'b0;
               st_d  = ST_FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st_q    <= ST_FETCH;
         pc_q    <= RESET_PC;
         vld_q   <= 1'b0;
         instr_q <= 32'h0;
         opc_q   <= 32'h0;
         cnt_q   <= 16'h0;
      end else begin
         st_q    <= st_d;
         pc_q    <= pc_d;
         vld_q   <= vld_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign out_valid   = vld_q;
   assign out_instr   = instr_q;
   assign out_pc      = opc_q;
   assign state       = st_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table, a reset-in-HALTED sequence,
// then randomized traffic against a behavioural model.
module tb_instr_fetch_ctrl;

   localparam int unsigned MEM_SIZE  = 1024;
   localparam logic [31:0] RESET_PC  = 32'h0;
   localparam logic [31:0] HALT_WORD = 32'h0;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [1:0]  state;
   logic [15:0] fetch_count;

   logic [31:0] rom [0:255];

   int checks   = 0;
   int failures = 0;

   instr_fetch_ctrl #(
      .MEM_SIZE (MEM_SIZE),
      .RESET_PC (RESET_PC),
      .HALT_WORD(HALT_WORD)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .state         (state),
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   always_comb imem_instr = rom[imem_addr[9:2]];

   typedef struct {
      logic        rn;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] ei;
      logic [1:0]  est;
      logic [15:0] ecnt;
      logic [31:0] eaddr;
   } vec_t;

   function automatic vec_t mk(input logic rn, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic ev, input logic [31:0] epc,
                               input logic [31:0] ei, input logic [1:0] est,
                               input logic [15:0] ecnt, input logic [31:0] eaddr);
      vec_t v;
      v.rn = rn; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
      v.ev = ev; v.epc = epc; v.ei = ei; v.est = est; v.ecnt = ecnt; v.eaddr = eaddr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] ei, input logic [1:0] est,
                            input logic [15:0] ecnt, input logic [31:0] eaddr);
      check({tag, ".out_valid"},   32'(out_valid),   32'(ev));
      check({tag, ".out_pc"},      out_pc,           epc);
      check({tag, ".out_instr"},   out_instr,        ei);
      check({tag, ".state"},       32'(state),       32'(est));
      check({tag, ".fetch_count"}, 32'(fetch_count), 32'(ecnt));
      check({tag, ".imem_addr"},   imem_addr,        eaddr);
   endtask

   task automatic drive(input logic rn, input logic rv, input logic [31:0] rpc, input logic rdy);
      reset_n        = rn;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Behavioural model of the fetch unit, kept at the level of the rules.
   logic [31:0] m_pc, m_instr, m_opc;
   logic        m_valid;
   int          m_state;
   int          m_count;

   task automatic model_step(input logic rn, input logic rv, input logic [31:0] rpc,
                             input logic rdy);
      bit          took;
      bit          bad;
      logic [31:0] word;
      if (!rn) begin
         m_pc = RESET_PC; m_valid = 0; m_instr = 0; m_opc = 0; m_count = 0; m_state = 0;
         return;
      end
      if (rv) begin
         m_pc = rpc; m_valid = 0; m_state = 0;
         return;
      end
      took = m_valid && rdy;
      if (took && m_count < 65535) m_count = m_count + 1;
      if (m_state == 0) begin
         if (!m_valid || rdy) begin
            bad = (m_pc % 4 != 0) || (longint'(m_pc) + 3 >= longint'(MEM_SIZE));
            if (bad) begin
               m_valid = 0;
               m_state = 2;
            end else begin
               word    = rom[m_pc / 4];
               m_instr = word;
               m_opc   = m_pc;
               m_valid = 1;
               m_pc    = m_pc + 32'd4;
               if (word == HALT_WORD) m_state = 1;
            end
         end
      end else if (took) begin
         m_valid = 0;
      end
   endtask

   vec_t vecs [26];

   initial begin
      int          budget;
      logic        rn, rv, rdy;
      logic [31:0] rpc;

      for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | 32'(i);
      rom[3] = HALT_WORD;

      //            rn rv rpc        rdy  ev epc        instr          st ecnt eaddr
      vecs[0]  = mk(0, 0, 32'h0,     1,   0, 32'h0,     32'h0,         0, 0, 32'h0);
      vecs[1]  = mk(1, 0, 32'h0,     1,   1, 32'h0,     32'hA000_0000, 0, 0, 32'h4);
      vecs[2]  = mk(1, 0, 32'h0,     1,   1, 32'h4,     32'hA000_0001, 0, 1, 32'h8);
      vecs[3]  = mk(1, 0, 32'h0,     1,   1, 32'h8,     32'hA000_0002, 0, 2, 32'hC);
      vecs[4]  = mk(1, 0, 32'h0,     1,   1, 32'hC,     32'h0,         1, 3, 32'h10);
      vecs[5]  = mk(1, 0, 32'h0,     0,   1, 32'hC,     32'h0,         1, 3, 32'h10);
      vecs[6]  = mk(1, 0, 32'h0,     1,   0, 32'hC,     32'h0,         1, 4, 32'h10);
      vecs[7]  = mk(1, 0, 32'h0,     1,   0, 32'hC,     32'h0,         1, 4, 32'h10);
      vecs[8]  = mk(1, 1, 32'h0,     1,   0, 32'hC,     32'h0,         0, 4, 32'h0);
      vecs[9]  = mk(1, 0, 32'h0,     0,   1, 32'h0,     32'hA000_0000, 0, 4, 32'h4);
      vecs[10] = mk(1, 0, 32'h0,     0,   1, 32'h0,     32'hA000_0000, 0, 4, 32'h4);
      vecs[11] = mk(1, 0, 32'h0,     1,   1, 32'h4,     32'hA000_0001, 0, 5, 32'h8);
      vecs[12] = mk(1, 0, 32'h0,     0,   1, 32'h4,     32'hA000_0001, 0, 5, 32'h8);
      vecs[13] = mk(1, 0, 32'h0,     0,   1, 32'h4,     32'hA000_0001, 0, 5, 32'h8);
      vecs[14] = mk(1, 0, 32'h0,     0,   1, 32'h4,     32'hA000_0001, 0, 5, 32'h8);
      vecs[15] = mk(1, 0, 32'h0,     1,   1, 32'h8,     32'hA000_0002, 0, 6, 32'hC);
      vecs[16] = mk(1, 1, 32'h40,    0,   0, 32'h8,     32'hA000_0002, 0, 6, 32'h40);
      vecs[17] = mk(1, 0, 32'h0,     1,   1, 32'h40,    32'hA000_0010, 0, 6, 32'h44);
      vecs[18] = mk(1, 1, 32'h3FE,   1,   0, 32'h40,    32'hA000_0010, 0, 6, 32'h3FE);
      vecs[19] = mk(1, 0, 32'h0,     1,   0, 32'h40,    32'hA000_0010, 2, 6, 32'h3FE);
      vecs[20] = mk(1, 0, 32'h0,     1,   0, 32'h40,    32'hA000_0010, 2, 6, 32'h3FE);
      vecs[21] = mk(1, 1, 32'h3FC,   1,   0, 32'h40,    32'hA000_0010, 0, 6, 32'h3FC);
      vecs[22] = mk(1, 0, 32'h0,     0,   1, 32'h3FC,   32'hA000_00FF, 0, 6, 32'h400);
      vecs[23] = mk(1, 0, 32'h0,     1,   0, 32'h3FC,   32'hA000_00FF, 2, 7, 32'h400);
      vecs[24] = mk(1, 0, 32'h0,     1,   0, 32'h3FC,   32'hA000_00FF, 2, 7, 32'h400);
      vecs[25] = mk(0, 1, 32'h80,    1,   0, 32'h0,     32'h0,         0, 0, 32'h0);

      drive(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);

      for (int i = 0; i < 26; i++) begin
         drive(vecs[i].rn, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ei,
                   vecs[i].est, vecs[i].ecnt, vecs[i].eaddr);
      end

      // Reset taken while HALTED with a non-zero count.
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      step();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      budget = 0;
      do begin
         step();
         budget++;
      end while (state != 2'd1 && budget < 10);
      check("halt_wait.state", 32'(state), 32'd1);
      check("halt_wait.out_pc", out_pc, 32'hC);
      step();
      drive(1'b1, 1'b1, 32'hC, 1'b1);
      step();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      step();
      check("halt2.out_valid", 32'(out_valid), 32'd1);
      check("halt2.state", 32'(state), 32'd1);
      step();
      check("pre_reset.fetch_count", 32'(fetch_count), 32'd5);
      check("pre_reset.state", 32'(state), 32'd1);
      check("pre_reset.out_valid", 32'(out_valid), 32'd0);
      drive(1'b0, 1'b1, 32'h80, 1'b1);
      step();
      check_all("halt_reset", 1'b0, 32'h0, 32'h0, 2'd0, 16'd0, RESET_PC);
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step();
      check_all("first_fetch", 1'b1, RESET_PC, rom[RESET_PC[9:2]], 2'd0, 16'd0, RESET_PC + 32'd4);

      // Randomized traffic against the model.
      for (int i = 0; i < 256; i++) begin
         logic [31:0] w;
         w = $urandom;
         if (w == HALT_WORD) w = 32'h1234_5678;
         if ($urandom_range(0, 15) == 0) w = HALT_WORD;
         rom[i] = w;
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      model_step(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      for (int cyc = 0; cyc < 1500; cyc++) begin
         rn  = ($urandom_range(0, 99) != 0);
         rv  = ($urandom_range(0, 11) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 5))
            0, 1, 2: rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            3:       rpc = 32'h3FC;
            4:       rpc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            default: rpc = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC
                                                       : 32'h400 + 32'($urandom_range(0, 63)) * 4;
         endcase
         drive(rn, rv, rpc, rdy);
         @(posedge clk);
         model_step(rn, rv, rpc, rdy);
         @(negedge clk);
         check_all($sformatf("rand%0d", cyc), m_valid, m_opc, m_instr, 2'(m_state),
                   16'(m_count), m_pc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, instruction memory size in bytes (power of 2, >4).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch byte address after reset.
REQ-003 SHALL have parameter HALT_WORD, default 32'h0, instruction encoding that stops fetching.
REQ-004 SHALL have port: clk, input, 1, single clock, all state updates on rising edge.
REQ-005 SHALL have port: reset_n, input, 1, synchronous, active-low reset.
REQ-006 SHALL have port: imem_addr, output, 32, byte address to the combinational instruction ROM.
REQ-007 SHALL have port: imem_instr, input, 32, ROM read data for imem_addr, same cycle.
REQ-008 SHALL have port: redirect_valid, input, 1, one-cycle request to restart fetch at redirect_pc.
REQ-009 SHALL have port: redirect_pc, input, 32, redirect target byte address.
REQ-010 SHALL have port: out_valid, output, 1, out_instr/out_pc hold a fetched instruction.
REQ-011 SHALL have port: out_ready, input, 1, consumer accepts the output this cycle.
REQ-012 SHALL have port: out_instr, output, 32, fetched instruction.
REQ-013 SHALL have port: out_pc, output, 32, address of out_instr.
REQ-014 SHALL have port: state, output, 2, FETCH=0, HALTED=1, FAULT=2.
REQ-015 SHALL have port: fetch_count, output, 16, instructions accepted (out_valid and out_ready) since reset.

Function
REQ-016 SHALL drive imem_addr combinationally from the internal pc register.
REQ-017 SHALL define "slot free" as out_valid==0 or out_ready==1.
REQ-018 SHALL define "pc bad" as pc[1:0]!=0 or pc+3 >= MEM_SIZE (compared at 33-bit width, no wrap).
REQ-019 SHALL, in FETCH with slot free, no redirect and pc not bad, load out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4 (modulo 2^32).
REQ-020 SHALL, in FETCH with slot free and pc bad, set out_valid<=0, leave pc unchanged and move to FAULT.
REQ-021 SHALL, in FETCH with slot not free, hold pc, out_instr, out_pc and out_valid (stall, no fetch).
REQ-022 SHALL, when a word equal to HALT_WORD is loaded per REQ-019, still deliver it, hold pc at its address+4 and move to HALTED.
REQ-023 SHALL, in HALTED or FAULT, perform no fetches; out_valid clears when the held entry is accepted and stays 0.
REQ-024 SHALL give redirect_valid priority over all other actions in every state: pc<=redirect_pc, out_valid<=0 (entry discarded, not counted), state<=FETCH.
REQ-025 SHALL, on a redirect to a bad pc, enter FETCH then FAULT on the next cycle per REQ-020.
REQ-026 SHALL give a fetch-to-out_valid latency of exactly one clock; back-to-back with out_ready=1 SHALL sustain one instruction per cycle.
REQ-027 SHALL increment fetch_count on each cycle with out_valid and out_ready high, saturating at 16'hFFFF; a simultaneous redirect SHALL NOT count.
REQ-028 SHALL keep out_instr/out_pc stable whenever out_valid=1 and out_ready=0.

Reset
REQ-029 SHALL, on a rising edge with reset_n=0, set pc<=RESET_PC, out_valid<=0, out_instr<=0, out_pc<=0, fetch_count<=0, state<=FETCH, regardless of any other input.
REQ-030 SHALL, on reset asserted mid-stall, mid-redirect, HALTED or FAULT, discard all in-flight state identically to REQ-029.
REQ-031 SHALL issue the first fetch on the first edge with reset_n=1; out_valid=1 one clock later.

Verification
REQ-032 SHALL cover streaming: ROM words A,B,C at 0,4,8, out_ready=1 -> out_pc 0,4,8 on consecutive cycles, fetch_count=3.
REQ-033 SHALL cover stall: out_ready=0 for 3 cycles with out_pc=4 -> out_pc/out_instr held at 4/B, imem_addr=8 held, then resume at 8.
REQ-034 SHALL cover redirect during stall: out_valid=1, out_ready=0, redirect to 0x40 -> next cycle out_valid=0, then out_pc=0x40, fetch_count unchanged.
REQ-035 SHALL cover halt: HALT_WORD at 0x0C -> delivered with out_pc=0x0C, state=HALTED, no further out_valid; redirect to 0 resumes FETCH.
REQ-036 SHALL cover fault: redirect to 0x3FE (misaligned) and to 0x3FC+4=0x400 (MEM_SIZE 1024) -> state=FAULT, out_valid=0, pc held.
REQ-037 SHALL cover reset: reset_n=0 for one edge during HALTED with fetch_count=5 -> state=FETCH, fetch_count=0, out_valid=0, imem_addr=RESET_PC.
